// File: rtl/serial_pkg.sv
// serial_pkg: tx states, line levels and frame-slot numbering shared with the receiver.
// Optional SERIAL_PARITY_EN inserts an even-parity slot before the stop bit.
package serial_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP
`ifdef SERIAL_PARITY_EN
        , ST_PARITY
`endif
    } tx_state_t;
    localparam logic IDLE_LVL  = 1'b0;
    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    localparam int DATA_BITS = 8;
    localparam logic [3:0] SLOT_START     = 4'd0;
    localparam logic [3:0] SLOT_DATA0     = 4'd1;
    localparam logic [3:0] SLOT_DATA_LAST = 4'd8;
`ifdef SERIAL_PARITY_EN
    localparam logic [3:0] SLOT_PARITY = 4'd9;
    localparam logic [3:0] SLOT_STOP   = 4'd10;
`else
    localparam logic [3:0] SLOT_STOP   = 4'd9;
`endif
endpackage

// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if: two requester channels plus the framed serial line and status.
interface serial_tx_arbiter_if;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       grant0, grant1;
    logic       data_out, busy;
    logic [3:0] bit_idx;
    modport master (output req0, req1, data0, data1,
                    input grant0, grant1, data_out, busy, bit_idx);
    modport slave (input req0, req1, data0, data1,
                   output grant0, grant1, data_out, busy, bit_idx);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin select; the pointer remembers the last winner.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic win
);
    logic ptr;
    assign win = (req0 && req1) ? ~ptr : req1;
    always_ff @(posedge clk)
        if (reset) ptr <= 1'b1;
        else if (accept) ptr <= win;
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin shares one serial tx line; frame = high start, 8 data LSB first, low stop.
// Define SERIAL_PARITY_EN to add an even-parity slot between the data bits and the stop bit.
module serial_tx_arbiter import serial_pkg::*; #(
    parameter int BIT_CYCLES = 16,
    parameter int DATA_BITS  = 8
) (
    input logic clk,
    input logic reset,
    serial_tx_arbiter_if.slave bus
);
    localparam int CW = $clog2(BIT_CYCLES);
`ifdef SERIAL_PARITY_EN
    localparam tx_state_t AFTER_DATA = ST_PARITY;
`else
    localparam tx_state_t AFTER_DATA = ST_STOP;
`endif
    tx_state_t state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [DATA_BITS-1:0] shreg, nxt_shreg;
    logic [3:0] idx, nxt_idx;
    logic win, accept, wrap, tail_lvl, nxt_lvl;
    rr_arbiter2 u_rr (.clk(clk), .reset(reset), .req0(bus.req0), .req1(bus.req1), .accept(accept), .win(win));
    assign accept = state == ST_IDLE && (bus.req0 || bus.req1);
    assign wrap = cnt == CW'(BIT_CYCLES - 1);
    assign bus.bit_idx = idx;
    always_comb begin
        nxt_state = state;
        nxt_cnt = wrap ? '0 : cnt + 1'b1;
        nxt_shreg = shreg;
        nxt_idx = idx;
        case (state)
            ST_IDLE: begin
                nxt_cnt = '0;
                nxt_idx = SLOT_START;
                if (accept) begin
                    nxt_state = ST_START;
                    nxt_shreg = win ? bus.data1 : bus.data0;
                end
            end
            ST_START: if (wrap) begin
                nxt_state = ST_DATA;
                nxt_idx = SLOT_DATA0;
            end
            ST_DATA: if (wrap) begin
                nxt_shreg = shreg >> 1;
                nxt_idx = idx + 4'd1;
                nxt_state = idx == SLOT_DATA_LAST ? AFTER_DATA : ST_DATA;
            end
`ifdef SERIAL_PARITY_EN
            ST_PARITY: if (wrap) begin
                nxt_state = ST_STOP;
                nxt_idx = SLOT_STOP;
            end
`endif
            ST_STOP: if (wrap) begin
                nxt_state = ST_IDLE;
                nxt_idx = SLOT_START;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end
`ifdef SERIAL_PARITY_EN
    logic par;
    assign tail_lvl = nxt_state == ST_PARITY ? par : STOP_LVL;
    always_ff @(posedge clk)
        if (reset) par <= 1'b0;
        else if (accept) par <= ^nxt_shreg;
`else
    assign tail_lvl = STOP_LVL;
`endif
    // line level is registered from the next state so it lines up with state/bit_idx
    assign nxt_lvl = nxt_state == ST_START ? START_LVL :
                     nxt_state == ST_DATA  ? nxt_shreg[0] :
                     nxt_state == ST_IDLE  ? IDLE_LVL : tail_lvl;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= '0;
            shreg <= '0;
            idx <= '0;
            bus.data_out <= IDLE_LVL;
            bus.busy <= 1'b0;
            bus.grant0 <= 1'b0;
            bus.grant1 <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt <= nxt_cnt;
            shreg <= nxt_shreg;
            idx <= nxt_idx;
            bus.data_out <= nxt_lvl;
            bus.busy <= nxt_state != ST_IDLE;
            bus.grant0 <= accept && !win;
            bus.grant1 <= accept && win;
        end
    end
endmodule
